// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: state encoding, BCD digit limits
// and the next-state rule for the run/pause/clear controller.
package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t PAUSE = 2'd2;

  localparam logic [3:0] ONES_MAX     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  localparam int DEFAULT_TICK_DIV = 50_000_000;

  // clear dominates start_stop; start_stop toggles between RUN and PAUSE
  function automatic state_t next_state(input state_t cur,
                                        input logic   start_stop,
                                        input logic   clear);
    if (clear) return IDLE;
    if (!start_stop) return cur;
    case (cur)
      RUN:     return PAUSE;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/bcd_stopwatch_core_if.sv
// Control/display bundle between the stopwatch core and its user.
// The lap input exists only when BCD_STOPWATCH_LAP_HOLD_EN is defined.
interface bcd_stopwatch_core_if;

  logic       start_stop;
  logic       clear;
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
  logic       lap;
`endif
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       tick;
  logic       wrap;

`ifdef BCD_STOPWATCH_LAP_HOLD_EN
  modport master (
    output start_stop, clear, lap,
    input  sec_ones, sec_tens, min_ones, min_tens, running, tick, wrap
  );
  modport slave (
    input  start_stop, clear, lap,
    output sec_ones, sec_tens, min_ones, min_tens, running, tick, wrap
  );
`else
  modport master (
    output start_stop, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, running, tick, wrap
  );
  modport slave (
    input  start_stop, clear,
    output sec_ones, sec_tens, min_ones, min_tens, running, tick, wrap
  );
`endif

endinterface

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch carry chain; rolls over MAX -> 0 and
// reports a combinational carry on the increment that rolls it over.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = ONES_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc & (digit == MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      digit <= '0;
    else if (clr)
      digit <= '0;
    else if (inc)
      digit <= (digit == MAX) ? 4'd0 : digit + 4'd1;
  end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// MM:SS BCD stopwatch: prescaler to a count tick, run/pause/clear control,
// four-digit carry chain. Optional lap hold under BCD_STOPWATCH_LAP_HOLD_EN.
module bcd_stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int CNT_W    = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_stopwatch_core_if.slave  sw
);

  state_t             state;
  state_t             nstate;
  logic [CNT_W-1:0]   prescaler;
  logic               tc;
  logic               running;
  logic               tick;
  logic               wrap;
  logic [3:0]         sec_ones, sec_tens, min_ones, min_tens;
  logic               c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;
  logic [15:0]        live;
  logic [15:0]        shown;

  assign nstate = next_state(state, sw.start_stop, sw.clear);
  assign tc     = (state == RUN) && (prescaler == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= nstate;
      running <= (nstate == RUN);
    end
  end

  // Prescaler holds in PAUSE so a resume finishes the partial second
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prescaler <= '0;
    else if (sw.clear || state == IDLE)
      prescaler <= '0;
    else if (state == RUN)
      prescaler <= tc ? '0 : prescaler + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= tc & ~sw.clear;
      wrap <= c_min_tens & ~sw.clear;
    end
  end

  bcd_digit_cnt #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(sw.clear), .inc(tc),
    .digit(sec_ones), .carry(c_sec_ones)
  );

  bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(sw.clear), .inc(c_sec_ones),
    .digit(sec_tens), .carry(c_sec_tens)
  );

  bcd_digit_cnt #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .clr(sw.clear), .inc(c_sec_tens),
    .digit(min_ones), .carry(c_min_ones)
  );

  bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .clr(sw.clear), .inc(c_min_ones),
    .digit(min_tens), .carry(c_min_tens)
  );

  assign live = {min_tens, min_ones, sec_tens, sec_ones};

`ifdef BCD_STOPWATCH_LAP_HOLD_EN
  logic        hold;
  logic [15:0] held;

  // Lap toggles the freeze only while running; entering IDLE drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold <= 1'b0;
    else if (sw.clear || nstate == IDLE)
      hold <= 1'b0;
    else if (sw.lap && state == RUN)
      hold <= ~hold;
  end

  always_ff @(posedge clk) begin
    if (sw.lap && state == RUN && !hold && !sw.clear)
      held <= live;
  end

  assign shown = hold ? held : live;
`else
  assign shown = live;
`endif

  assign sw.min_tens = shown[15:12];
  assign sw.min_ones = shown[11:8];
  assign sw.sec_tens = shown[7:4];
  assign sw.sec_ones = shown[3:0];
  assign sw.running  = running;
  assign sw.tick     = tick;
  assign sw.wrap     = wrap;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Bench for bcd_stopwatch_core with TICK_DIV=4: a seconds-count model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bcd_stopwatch_core;

  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_stopwatch_core_if sw();

  bcd_stopwatch_core #(.TICK_DIV(TICK_DIV), .CNT_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: state 0=idle 1=run 2=pause, elapsed time as plain seconds
  int m_state = 0;
  int m_pre   = 0;
  int m_secs  = 0;
  int m_held  = 0;
  bit m_tick  = 1'b0;
  bit m_wrap  = 1'b0;
  bit m_hold  = 1'b0;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit model_tc();
    return (m_state == 1) && (m_pre == TICK_DIV - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_pre <= 0; m_secs <= 0;
      m_tick <= 1'b0; m_wrap <= 1'b0; m_hold <= 1'b0;
    end else if (sw.clear) begin
      m_state <= 0; m_pre <= 0; m_secs <= 0;
      m_tick <= 1'b0; m_wrap <= 1'b0; m_hold <= 1'b0;
    end else begin
      m_tick <= model_tc();
      m_wrap <= model_tc() && (m_secs == 3599);
      if (model_tc()) m_secs <= (m_secs + 1) % 3600;
      if (m_state == 1) m_pre <= (m_pre + 1) % TICK_DIV;
      if (sw.start_stop) m_state <= (m_state == 1) ? 2 : 1;
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
      if (sw.lap && m_state == 1) begin
        m_hold <= !m_hold;
        if (!m_hold) m_held <= m_secs;
      end
`endif
    end
  end

  function automatic logic [15:0] dut_digits();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_digits", 32'(dut_digits()), 32'(to_bcd(m_hold ? m_held : m_secs)));
      chk("model_tick", 32'(sw.tick), 32'(m_tick));
      chk("model_wrap", 32'(sw.wrap), 32'(m_wrap));
      chk("model_running", 32'(sw.running), 32'(m_state == 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_ss();
    sw.start_stop = 1'b1;
    step();
    sw.start_stop = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    int seen;
    int budget;
    seen   = 0;
    budget = n * TICK_DIV + 8;
    while (seen < n && budget > 0) begin
      step();
      budget--;
      if (sw.tick) seen++;
    end
    chk("ticks_seen", 32'(seen), 32'(n));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int n;
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
`ifdef BCD_STOPWATCH_LAP_HOLD_EN
    sw.lap        = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) step();
    chk("reset_digits", 32'(dut_digits()), 32'h0);
    chk("reset_running", 32'(sw.running), 32'h0);
    chk("reset_tick", 32'(sw.tick), 32'h0);
    chk("reset_wrap", 32'(sw.wrap), 32'h0);
    rst = 1'b0;
    check_en = 1'b1;
    step();

    // Start and count ten ticks in 40 cycles
    pulse_ss();
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sw.tick) ticks++;
    end
    chk("t1_ticks", 32'(ticks), 32'd10);
    chk("t1_digits", 32'(dut_digits()), 32'h0010);
    chk("t1_running", 32'(sw.running), 32'h1);

    // 00:59 -> 01:00
    run_ticks(49);
    chk("t2_0059", 32'(dut_digits()), 32'h0059);
    run_ticks(1);
    chk("t2_0100", 32'(dut_digits()), 32'h0100);
    chk("t2_tick", 32'(sw.tick), 32'h1);
    chk("t2_wrap", 32'(sw.wrap), 32'h0);

    // 59:59 -> 00:00 with wrap, then keep counting
    run_ticks(3539);
    chk("t3_5959", 32'(dut_digits()), 32'h5959);
    chk("t3_wrap_pre", 32'(sw.wrap), 32'h0);
    run_ticks(1);
    chk("t3_0000", 32'(dut_digits()), 32'h0000);
    chk("t3_tick", 32'(sw.tick), 32'h1);
    chk("t3_wrap", 32'(sw.wrap), 32'h1);
    step();
    chk("t3_wrap_once", 32'(sw.wrap), 32'h0);
    chk("t3_tick_once", 32'(sw.tick), 32'h0);
    run_ticks(1);
    chk("t3_0001", 32'(dut_digits()), 32'h0001);

    // Pause with the prescaler at 2, resume finishes the partial second
    step();
    pulse_ss();
    chk("t4_paused", 32'(sw.running), 32'h0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sw.tick) ticks++;
    end
    chk("t4_no_ticks", 32'(ticks), 32'h0);
    chk("t4_hold_digits", 32'(dut_digits()), 32'h0001);
    pulse_ss();
    n = 0;
    while (n < 10) begin
      step();
      n++;
      if (sw.tick) break;
    end
    chk("t4_resume_latency", 32'(n), 32'd2);
    chk("t4_digits", 32'(dut_digits()), 32'h0002);

    // Simultaneous start_stop and clear at 00:07
    run_ticks(5);
    chk("t5_0007", 32'(dut_digits()), 32'h0007);
    sw.start_stop = 1'b1;
    sw.clear      = 1'b1;
    step();
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    chk("t5_clr_running", 32'(sw.running), 32'h0);
    chk("t5_clr_digits", 32'(dut_digits()), 32'h0000);

    // clear on the terminal-count edge
    pulse_ss();
    repeat (3) step();
    sw.clear = 1'b1;
    step();
    sw.clear = 1'b0;
    chk("t5_clr_tc_tick", 32'(sw.tick), 32'h0);
    chk("t5_clr_tc_digits", 32'(dut_digits()), 32'h0000);

    // start_stop on the terminal-count edge: increment lands, then pause
    pulse_ss();
    repeat (3) step();
    pulse_ss();
    chk("t5_ss_tc_tick", 32'(sw.tick), 32'h1);
    chk("t5_ss_tc_digits", 32'(dut_digits()), 32'h0001);
    chk("t5_ss_tc_running", 32'(sw.running), 32'h0);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (sw.tick) ticks++;
    end
    chk("t5_ss_tc_paused", 32'(ticks), 32'h0);

    // Asynchronous reset mid-count
    pulse_ss();
    run_ticks(3);
    step();
    chk("t5_pre_rst_digits", 32'(dut_digits()), 32'h0004);
    rst = 1'b1;
    #1;
    chk("t5_async_digits", 32'(dut_digits()), 32'h0000);
    chk("t5_async_running", 32'(sw.running), 32'h0);
    chk("t5_async_tick", 32'(sw.tick), 32'h0);
    chk("t5_async_wrap", 32'(sw.wrap), 32'h0);
    step();
    rst = 1'b0;
    step();

`ifdef BCD_STOPWATCH_LAP_HOLD_EN
    // Lap freezes the display while the count runs on
    pulse_ss();
    run_ticks(3);
    chk("t6_0003", 32'(dut_digits()), 32'h0003);
    sw.lap = 1'b1;
    step();
    sw.lap = 1'b0;
    run_ticks(5);
    chk("t6_frozen", 32'(dut_digits()), 32'h0003);
    chk("t6_tick_live", 32'(sw.tick), 32'h1);
    sw.lap = 1'b1;
    step();
    sw.lap = 1'b0;
    chk("t6_released", 32'(dut_digits()), 32'h0008);
    pulse_ss();
    sw.lap = 1'b1;
    step();
    sw.lap = 1'b0;
    step();
    chk("t6_pause_lap_ignored", 32'(dut_digits()), 32'h0008);
`endif

    step();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_core.md
Name: bcd_stopwatch_core

Overview:
- Upstream timekeeping stage for the board's multiplexed 7-segment display driver.
- Divides the 50 MHz `clk` down to a 1 Hz tick and counts MM:SS from 00:00 to 59:59 in packed BCD.
- Start/stop and clear are controlled through a small state machine.
- Digit outputs are registered and held stable between ticks, so the display driver can sample them asynchronously to its own refresh clock.

Parameters:
- TICK_DIV, 50000000, number of `clk` cycles per count tick; must be ≥2; benches use 4.
- CNT_W, 26, prescaler width; must hold TICK_DIV-1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-high reset.
- start_stop  in  1  single-cycle synchronous pulse (already debounced); toggles run/pause.
- clear  in  1  single-cycle synchronous pulse; zeroes the time and returns to IDLE.
- lap  in  1  single-cycle pulse; present only when LAP_HOLD_EN is defined.
- sec_ones  out  4  BCD 0-9.
- sec_tens  out  4  BCD 0-5.
- min_ones  out  4  BCD 0-9.
- min_tens  out  4  BCD 0-5.
- running  out  1  high in RUN state.
- tick  out  1  one-cycle pulse, coincident with a digit update.
- wrap  out  1  one-cycle pulse when 59:59 rolls over to 00:00.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, prescaler=0.
  - All digits=0, running=0, tick=0, wrap=0.
  - Lap hold cleared.
- States and transitions:
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> PAUSE.
  - PAUSE --start_stop--> RUN.
  - Any state --clear--> IDLE.
- Simultaneous start_stop and clear: clear wins; next state is IDLE and start_stop is ignored.
- Prescaler:
  - Counts only in RUN.
  - Counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and asserts the internal terminal count (tc).
  - In PAUSE it holds its value, so resume continues the partial second.
  - Cleared in IDLE.
- Digit update:
  - Occurs on the clock edge where tc=1 while in RUN.
  - tick is registered high for exactly that one following cycle, aligned with the new digit values.
  - Latency: first increment happens TICK_DIV cycles after entering RUN from IDLE.
- Carry chain (all in the same edge):
  - sec_ones 9→0, carry into sec_tens.
  - sec_tens 5→0, carry into min_ones.
  - min_ones 9→0, carry into min_tens.
  - min_tens 5→0 at 59:59, asserts wrap for one cycle with tick; counting continues from 00:00.
- Digits never take non-BCD values. Illegal values cannot occur from reset; no recovery logic is required.
- start_stop arriving on the same edge as tc in RUN:
  - The increment is applied.
  - State becomes PAUSE.
  - Prescaler wraps to 0.
- clear arriving on the same edge as tc: clear wins; digits=0, tick=0, wrap=0.
- running is a registered decode of state==RUN.

Optional Feature:
- Macro: BCD_STOPWATCH_LAP_HOLD_EN.
- Defined:
  - `lap` port exists.
  - In RUN, lap toggles a hold flag.
  - While the hold flag is set, the output digits freeze at the value captured on the lap edge, while the internal count keeps running.
  - tick and wrap continue to reflect the internal count.
  - A second lap releases the hold; outputs show the live count on the next cycle.
  - Hold is cleared by clear, by rst, and on entry to IDLE.
  - lap is ignored in IDLE and PAUSE.
- Undefined: no `lap` port; outputs are always the live count.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding typedef (IDLE, RUN, PAUSE);
  - BCD limit constants SEC_TENS_MAX=5, MIN_TENS_MAX=5, ONES_MAX=9;
  - the default TICK_DIV.
- One sub-module: bcd_digit_cnt.
  - Parameter MAX.
  - Inputs: clk, rst, clr, inc.
  - Outputs: digit[3:0], carry (combinational, = inc & digit==MAX).
  - Instantiated four times in a carry chain.

Test Plan (TICK_DIV=4):
1. Reset, then pulse start_stop, run 40 cycles -> running=1; tick pulses every 4 cycles; after 10 ticks digits read 00:10 (sec_tens=1, sec_ones=0).
2. Preload by running to 00:59, then one more tick -> 01:00, tick=1, wrap=0 on that cycle.
3. Run to 59:59, then one more tick -> 00:00 with wrap=1 and tick=1 for exactly one cycle; counting continues.
4. Pause with the prescaler at 2 for 20 cycles, then resume -> no tick while paused; first tick after resume arrives exactly 2 cycles later.
5. start_stop and clear asserted on the same cycle during RUN at 00:07 -> next cycle state=IDLE, digits=00:00, running=0; assert rst mid-count -> all outputs 0 immediately, without waiting for a clock edge.
6. With BCD_STOPWATCH_LAP_HOLD_EN: lap at 00:03, run 5 ticks -> outputs hold 00:03 while ticks continue; second lap -> outputs show 00:08 the next cycle.
